// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART: FSM state encoding
// and the oversampling constants used by both the RX and TX sequencers.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam int OVS       = 16;
  localparam int MID_START = 7;

endpackage

// File: rtl/uart_fifo.sv
// Circular FIFO with registered empty/full flags and a first-word-fall-through head.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int DBIT   = 8,
  parameter int FIFO_W = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [DBIT-1:0] w_data,
  output logic [DBIT-1:0] r_data,
  output logic            empty,
  output logic            full
);

  localparam int DEPTH = 2 ** FIFO_W;

  logic [DBIT-1:0]   mem [DEPTH];
  logic [FIFO_W-1:0] wptr, rptr, wptr_inc, rptr_inc;
  logic              push_ok, pop_ok;

  assign pop_ok   = pop & ~empty;
  assign push_ok  = push & (~full | pop_ok);
  assign wptr_inc = wptr + 1'b1;
  assign rptr_inc = rptr + 1'b1;

  always_ff @(posedge clock) begin
    if (push_ok) mem[wptr] <= w_data;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr_inc;
      if (pop_ok)  rptr <= rptr_inc;
      case ({push_ok, pop_ok})
        2'b10: begin
          empty <= 1'b0;
          full  <= (wptr_inc == rptr);
        end
        2'b01: begin
          full  <= 1'b0;
          empty <= (rptr_inc == wptr);
        end
        default: ;
      endcase
    end
  end

  // Head reads as zero while empty so the output is defined out of reset.
  assign r_data = empty ? '0 : mem[rptr];

endmodule

// File: rtl/uart_fifo_param.sv
// Full-duplex UART, 16x oversampled, runtime baud divisor, RX/TX FIFOs, sticky errors.
// Optional parity bit and rx_parity_err when UART_PARITY_EN is defined.
//   state  | meaning
//   IDLE   | line idle (RX: waiting for low, TX: waiting for data on a tick)
//   START  | start bit (RX: qualify at mid-bit)
//   DATA   | data bits, LSB first, 16 ticks each
//   PARITY | parity bit (only with UART_PARITY_EN)
//   STOP   | stop bit, SB_TICK ticks
module uart_fifo_param
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int DVSR_W  = 11,
  parameter int FIFO_W  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DVSR_W-1:0] baud_div,
  input  logic              rd,
  input  logic              wr,
  input  logic [DBIT-1:0]   w_data,
  output logic [DBIT-1:0]   r_data,
  output logic              rx_empty,
  output logic              tx_full,
  output logic              rx_overrun,
  output logic              rx_frame_err,
  input  logic              err_clr,
`ifdef UART_PARITY_EN
  input  logic              parity_odd,
  output logic              rx_parity_err,
`endif
  input  logic              rx,
  output logic              tx
);

  localparam logic [5:0] S_MID   = 6'(MID_START);
  localparam logic [5:0] S_BIT   = 6'(OVS - 1);
  localparam logic [5:0] SB_LAST = 6'(SB_TICK - 1);
  localparam logic [3:0] N_LAST  = 4'(DBIT - 1);

  // Divisor is captured at each wrap so a mid-period change cannot overrun the compare.
  logic [DVSR_W-1:0] baud_cnt, div_q;
  logic              tick;

  assign tick = (baud_cnt == div_q);

  always_ff @(posedge clock) begin
    if (!reset || tick) begin
      baud_cnt <= '0;
      div_q    <= baud_div;
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

  logic rx_meta, rx_sync;

  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  logic            rx_push, rx_full, tx_pop, tx_empty;
  logic [DBIT-1:0] rx_word, tx_head;

  uart_fifo #(.DBIT(DBIT), .FIFO_W(FIFO_W)) u_rx_fifo (
    .clock(clock), .reset(reset), .push(rx_push), .pop(rd), .w_data(rx_word),
    .r_data(r_data), .empty(rx_empty), .full(rx_full)
  );

  uart_fifo #(.DBIT(DBIT), .FIFO_W(FIFO_W)) u_tx_fifo (
    .clock(clock), .reset(reset), .push(wr), .pop(tx_pop), .w_data(w_data),
    .r_data(tx_head), .empty(tx_empty), .full(tx_full)
  );

  uart_state_t     rx_state, rx_state_n;
  logic [5:0]      rs, rs_n;
  logic [3:0]      rn, rn_n;
  logic [DBIT-1:0] rb, rb_n;
  logic            frame_set;
`ifdef UART_PARITY_EN
  logic            par_set;
`endif

  assign rx_word = rb;

  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_state <= IDLE;
      rs       <= '0;
      rn       <= '0;
      rb       <= '0;
    end else begin
      rx_state <= rx_state_n;
      rs       <= rs_n;
      rn       <= rn_n;
      rb       <= rb_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rs_n       = rs;
    rn_n       = rn;
    rb_n       = rb;
    rx_push    = 1'b0;
    frame_set  = 1'b0;
`ifdef UART_PARITY_EN
    par_set    = 1'b0;
`endif
    case (rx_state)
      IDLE: if (!rx_sync) begin
        rx_state_n = START;
        rs_n       = '0;
      end
      START: if (tick) begin
        if (rs == S_MID) begin
          rs_n = '0;
          rn_n = '0;
          rx_state_n = rx_sync ? IDLE : DATA;
        end else begin
          rs_n = rs + 1'b1;
        end
      end
      DATA: if (tick) begin
        if (rs == S_BIT) begin
          rs_n = '0;
          rb_n = {rx_sync, rb[DBIT-1:1]};
          if (rn == N_LAST) begin
`ifdef UART_PARITY_EN
            rx_state_n = PARITY;
`else
            rx_state_n = STOP;
`endif
          end else begin
            rn_n = rn + 1'b1;
          end
        end else begin
          rs_n = rs + 1'b1;
        end
      end
`ifdef UART_PARITY_EN
      PARITY: if (tick) begin
        if (rs == S_BIT) begin
          rs_n       = '0;
          rx_state_n = STOP;
          par_set    = (rx_sync != ((^rb) ^ parity_odd));
        end else begin
          rs_n = rs + 1'b1;
        end
      end
`endif
      STOP: if (tick) begin
        if (rs == SB_LAST) begin
          rx_push    = 1'b1;
          frame_set  = ~rx_sync;
          rx_state_n = IDLE;
        end else begin
          rs_n = rs + 1'b1;
        end
      end
      default: rx_state_n = IDLE;
    endcase
  end

  // A simultaneous rd frees a slot, so the incoming frame is not lost then.
  logic overrun_set;
  assign overrun_set = rx_push & rx_full & ~rd;

  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_overrun    <= 1'b0;
      rx_frame_err  <= 1'b0;
`ifdef UART_PARITY_EN
      rx_parity_err <= 1'b0;
`endif
    end else begin
      if (overrun_set)  rx_overrun <= 1'b1;
      else if (err_clr) rx_overrun <= 1'b0;
      if (frame_set)    rx_frame_err <= 1'b1;
      else if (err_clr) rx_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
      if (par_set)      rx_parity_err <= 1'b1;
      else if (err_clr) rx_parity_err <= 1'b0;
`endif
    end
  end

  uart_state_t     tx_state, tx_state_n;
  logic [5:0]      ts, ts_n;
  logic [3:0]      tn, tn_n;
  logic [DBIT-1:0] tb, tb_n;
  logic            tx_reg, tx_n, load;
`ifdef UART_PARITY_EN
  logic            tp, tp_n;
`endif

  assign tx = tx_reg;

  always_ff @(posedge clock) begin
    if (!reset) begin
      tx_state <= IDLE;
      ts       <= '0;
      tn       <= '0;
      tb       <= '0;
      tx_reg   <= 1'b1;
`ifdef UART_PARITY_EN
      tp       <= 1'b0;
`endif
    end else begin
      tx_state <= tx_state_n;
      ts       <= ts_n;
      tn       <= tn_n;
      tb       <= tb_n;
      tx_reg   <= tx_n;
`ifdef UART_PARITY_EN
      tp       <= tp_n;
`endif
    end
  end

  // Frames start on a tick so every bit, including the start bit, is exactly 16 ticks.
  always_comb begin
    tx_state_n = tx_state;
    ts_n       = ts;
    tn_n       = tn;
    tb_n       = tb;
    tx_n       = tx_reg;
    tx_pop     = 1'b0;
    load       = 1'b0;
`ifdef UART_PARITY_EN
    tp_n       = tp;
`endif
    case (tx_state)
      IDLE: begin
        tx_n = 1'b1;
        if (tick && !tx_empty) load = 1'b1;
      end
      START: if (tick) begin
        if (ts == S_BIT) begin
          ts_n       = '0;
          tn_n       = '0;
          tx_state_n = DATA;
          tx_n       = tb[0];
        end else begin
          ts_n = ts + 1'b1;
        end
      end
      DATA: if (tick) begin
        if (ts == S_BIT) begin
          ts_n = '0;
          tb_n = tb >> 1;
          if (tn == N_LAST) begin
`ifdef UART_PARITY_EN
            tx_state_n = PARITY;
            tx_n       = tp;
`else
            tx_state_n = STOP;
            tx_n       = 1'b1;
`endif
          end else begin
            tn_n = tn + 1'b1;
            tx_n = tb[1];
          end
        end else begin
          ts_n = ts + 1'b1;
        end
      end
`ifdef UART_PARITY_EN
      PARITY: if (tick) begin
        if (ts == S_BIT) begin
          ts_n       = '0;
          tx_state_n = STOP;
          tx_n       = 1'b1;
        end else begin
          ts_n = ts + 1'b1;
        end
      end
`endif
      STOP: if (tick) begin
        if (ts == SB_LAST) begin
          if (!tx_empty) begin
            load = 1'b1;
          end else begin
            tx_state_n = IDLE;
            tx_n       = 1'b1;
          end
        end else begin
          ts_n = ts + 1'b1;
        end
      end
      default: begin
        tx_state_n = IDLE;
        tx_n       = 1'b1;
      end
    endcase
    if (load) begin
      tx_pop     = 1'b1;
      tb_n       = tx_head;
      ts_n       = '0;
      tx_state_n = START;
      tx_n       = 1'b0;
`ifdef UART_PARITY_EN
      tp_n       = (^tx_head) ^ parity_odd;
`endif
    end
  end

endmodule
